muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step per cycle, 32 steps per operation.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mq_q, mq_d;
  logic [31:0] mcand_q, mcand_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        bz_q, bz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ok;
  logic [31:0] acc_n;
  logic [31:0] mq_n;
  logic [63:0] prod_mag;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        last_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Operands are reduced to magnitudes at latch time; signs are reapplied on the final step.
  always_comb begin
    op_signed = ~op[0];
    a_neg     = op_signed & A[31];
    b_neg     = op_signed & B[31];
    a_mag     = a_neg ? (~A + 32'd1) : A;
    b_mag     = b_neg ? (~B + 32'd1) : B;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mcand_q : 32'd0)};
    div_shift = {acc_q, mq_q[31]};
    div_ok    = (div_shift >= {1'b0, mcand_q});
    div_diff  = div_shift[31:0] - mcand_q;
    if (is_div_q) begin
      acc_n = div_ok ? div_diff : div_shift[31:0];
      mq_n  = {mq_q[30:0], div_ok};
    end else begin
      acc_n = mul_sum[32:1];
      mq_n  = {mul_sum[0], mq_q[31:1]};
    end
    prod_mag = {acc_n, mq_n};
    prod_fix = neg_res_q ? (~prod_mag + 64'd1) : prod_mag;
    quo_fix  = neg_res_q ? (~mq_n + 32'd1) : mq_n;
    rem_fix  = neg_rem_q ? (~acc_n + 32'd1) : acc_n;
    // A zero divisor leaves |A| in the remainder, so only LO needs forcing.
    res_hi   = is_div_q ? rem_fix : prod_fix[63:32];
    res_lo   = is_div_q ? (bz_q ? 32'hFFFF_FFFF : quo_fix) : prod_fix[31:0];
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bz_d      = bz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    last_step = (state_q == S_RUN) && (cnt_q == 5'd31);
    if (state_q == S_RUN) begin
      acc_d = acc_n;
      mq_d  = mq_n;
      cnt_d = cnt_q + 5'd1;
      if (last_step) begin
        hi_d = res_hi;
        lo_d = res_lo;
      end
    end else begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
      if (start) begin
        cnt_d     = 5'd0;
        acc_d     = 32'd0;
        mq_d      = a_mag;
        mcand_d   = b_mag;
        is_div_d  = op[1];
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        bz_d      = (B == 32'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 5'd0;
      acc_q     <= 32'd0;
      mq_q      <= 32'd0;
      mcand_q   <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bz_q      <= bz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the stimulus process queues hand-computed
// HI/LO results and completion cycles; a negedge monitor checks them on done.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          doneCycle;
    string       name;
  } expT;

  expT sbQueue[$];
  int  compareCount = 0;
  int  failCount    = 0;
  int  cycleCount   = 0;
  int  busyRun      = 0;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter used to check the exact completion latency
  always @(posedge clk) cycleCount++;

  // One counted comparison; prints a FAIL line with both values on a miscompare
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  // Monitor: counts busy cycles and, on every done, pops the scoreboard and checks HI/LO/latency
  always @(negedge clk) begin
    expT e;
    if (rst) begin
      busyRun = 0;
    end else begin
      if (busy) busyRun++;
      if (done) begin
        if (sbQueue.size() == 0) begin
          compareCount++;
          failCount++;
          $display("[TB] FAIL unexpectedDone: got done=1 at cycle %0d expected no completion", cycleCount);
        end else begin
          e = sbQueue.pop_front();
          checkOutput({e.name, ".HI"}, HI, e.hi);
          checkOutput({e.name, ".LO"}, LO, e.lo);
          checkOutput({e.name, ".doneCycle"}, 32'(cycleCount), 32'(e.doneCycle));
          checkOutput({e.name, ".busyCycles"}, 32'(busyRun), 32'd32);
        end
        busyRun = 0;
      end
    end
  end

  // Issues one operation (called just after a negedge) and waits, bounded, for its done.
  // Optional MTHI/MTLO on the start edge, and an ignored start+write injected mid-RUN.
  task automatic applyStimulus(input string name, input logic [1:0] opV,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic hiWeV, input logic loWeV,
                               input logic [31:0] wd, input int injectAt);
    bit got;
    sbQueue.push_back('{expHi, expLo, cycleCount + 33, name});
    start = 1'b1;
    op    = opV;
    A     = a;
    B     = b;
    hi_we = hiWeV;
    lo_we = loWeV;
    wdata = wd;
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    A     = 32'h5A5A_5A5A;
    B     = 32'hA5A5_A5A5;
    if (hiWeV) checkOutput({name, ".startMthi"}, HI, wd);
    if (loWeV) checkOutput({name, ".startMtlo"}, LO, wd);
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (i == injectAt) begin
          start = 1'b1;
          op    = OP_DIVU;
          A     = 32'd1;
          B     = 32'd1;
          hi_we = 1'b1;
          lo_we = 1'b1;
          wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
    end
    if (!got) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL %s.timeout: got no done within 40 cycles expected done after 32", name);
      sbQueue.delete();
    end
  endtask

  // Main directed sequence
  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    A     = 32'd0;
    B     = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = 32'd0;
    #2 rst = 1'b1;
    #1;
    checkOutput("reset.HI", HI, 32'd0);
    checkOutput("reset.LO", LO, 32'd0);
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Start on the first edge after reset release, then chained starts taken from DONE
    applyStimulus("multuMax",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("multNeg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("divNeg7by2", OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("divMinByM1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("divu100by0", OP_DIVU, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("multMinSq",  OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("div7byNeg2", OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("divNeg100by0", OP_DIV, 32'hFFFF_FF9C, 32'd0,        32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("divuMaxBy16", OP_DIVU, 32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF, 1'b0, 1'b0, 32'd0, 0);
    applyStimulus("multM1x1",   OP_MULT, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 0);

    // Start and MTHI/MTLO pulsed during RUN must leave the running result untouched
    applyStimulus("ignoreInRun", OP_MULTU, 32'h1234_5678, 32'd16,      32'h0000_0001, 32'h2345_6780, 1'b0, 1'b0, 32'd0, 5);

    // MTLO then MTHI+MTLO together while idle
    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h0000_1234;
    @(negedge clk);
    lo_we = 1'b0;
    checkOutput("mtlo.LO", LO, 32'h0000_1234);
    checkOutput("mtlo.HI", HI, 32'h0000_0001);
    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput("mthilo.HI", HI, 32'hCAFE_F00D);
    checkOutput("mthilo.LO", LO, 32'hCAFE_F00D);

    // Writes coinciding with start land first, then the result overwrites them
    applyStimulus("writeWithStart", OP_MULTU, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, 1'b1, 1'b1, 32'hAAAA_5555, 0);

    // Reset mid-RUN: immediate clear without a clock edge, and no completion afterwards
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    A     = 32'd1000;
    B     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort.busy", {31'd0, busy}, 32'd0);
    checkOutput("abort.done", {31'd0, done}, 32'd0);
    checkOutput("abort.HI", HI, 32'd0);
    checkOutput("abort.LO", LO, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("abortAfter.HI", HI, 32'd0);
    checkOutput("abortAfter.LO", LO, 32'd0);

    // Normal operation resumes after the abort
    applyStimulus("divu1000by3", OP_DIVU, 32'd1000, 32'd3, 32'h0000_0001, 32'h0000_014D, 1'b0, 1'b0, 32'd0, 0);

    repeat (3) @(negedge clk);
    if (sbQueue.size() != 0) begin
      compareCount++;
      failCount++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", sbQueue.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", compareCount, failCount);
    $finish;
  end

endmodule
